// File: rtl/uc_pkg.sv
// Shared opcode encodings and sequencer state type for the 8-bit microcontroller control unit.
package uc_pkg;

    localparam logic [2:0] OPC_ALU_PFX = 3'b001;
    localparam logic [5:0] OPC_NOP     = 6'b000000;
    localparam logic [5:0] OPC_LI      = 6'b000010;
    localparam logic [5:0] OPC_WAIT    = 6'b000011;
    localparam logic [5:0] OPC_J       = 6'b000100;
    localparam logic [5:0] OPC_JZ      = 6'b000101;
    localparam logic [5:0] OPC_JNZ     = 6'b000110;
    localparam logic [5:0] OPC_HALT    = 6'b000111;

    localparam logic [2:0] ALU_PASSA   = 3'b000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        STALL = 2'd3
    } state_t;

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode/zero-flag decode for an executing cycle; the sequencer applies safe-set gating.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic       wez,
    output logic [2:0] op,
    output logic       is_halt,
    output logic       is_wait,
    output logic       is_illegal
);

    always_comb begin
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        op         = ALU_PASSA;
        is_halt    = 1'b0;
        is_wait    = 1'b0;
        is_illegal = 1'b0;
        if (opcode[5:3] == OPC_ALU_PFX) begin
            we3 = 1'b1;
            wez = 1'b1;
            op  = opcode[2:0];
        end else begin
            case (opcode)
                OPC_NOP:  ;
                OPC_LI: begin
                    we3   = 1'b1;
                    s_inm = 1'b1;
                end
                OPC_J:    s_inc = 1'b0;
                OPC_JZ:   s_inc = ~z;
                OPC_JNZ:  s_inc = z;
                OPC_HALT: is_halt = 1'b1;
                OPC_WAIT: is_wait = 1'b1;
                default:  is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit: boot settling, HALT/WAIT stalls, single-step gating, status and retire count.
module uc_seq
    import uc_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    input  logic             go,
    input  logic             dbg_en,
    input  logic             dbg_step,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned BW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

    state_t        state, state_nx;
    logic [BW-1:0] boot_cnt;
    logic          exec;

    logic       d_s_inc, d_s_inm, d_we3, d_wez;
    logic [2:0] d_op;
    logic       d_halt, d_wait, d_illegal;

    uc_decode u_decode (
        .opcode     (opcode),
        .z          (z),
        .s_inc      (d_s_inc),
        .s_inm      (d_s_inm),
        .we3        (d_we3),
        .wez        (d_wez),
        .op         (d_op),
        .is_halt    (d_halt),
        .is_wait    (d_wait),
        .is_illegal (d_illegal)
    );

    assign exec   = (state == RUN) && (!dbg_en || dbg_step);
    assign halted = (state == HALT);

    always_comb begin
        pc_en    = 1'b0;
        s_inc    = 1'b1;
        s_inm    = 1'b0;
        we3      = 1'b0;
        wez      = 1'b0;
        op       = ALU_PASSA;
        state_nx = state;
        unique case (state)
            // A boot count of 0 or 1 both leave BOOT on the first edge after release.
            BOOT: if (boot_cnt <= BW'(1)) state_nx = RUN;
            RUN: if (exec) begin
                s_inc = d_s_inc;
                s_inm = d_s_inm;
                we3   = d_we3;
                wez   = d_wez;
                op    = d_op;
                pc_en = !d_halt && !(d_wait && !go);
                if (d_halt)
                    state_nx = HALT;
                else if (d_wait && !go)
                    state_nx = STALL;
            end
            HALT, STALL: if (go) begin
                pc_en    = 1'b1;
                state_nx = RUN;
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            boot_cnt <= BW'(BOOT_CYCLES);
            retired  <= '0;
            illegal  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == BOOT && boot_cnt > BW'(1))
                boot_cnt <= boot_cnt - BW'(1);
            if (pc_en)
                retired <= retired + CNT_W'(1);
            if (exec && d_illegal)
                illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uc_seq.sv
// Directed plus randomized bench for uc_seq against a behavioural model of the sequencing rules.
module tb_uc_seq;

    localparam int unsigned BOOT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        z = 1'b0, go = 1'b0, dbg_en = 1'b0, dbg_step = 1'b0;
    logic        s_inc, s_inm, we3, wez, pc_en, halted, illegal;
    logic [2:0]  op;
    logic [15:0] retired;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model: mode 0=settling after reset, 1=running, 2=halted, 3=waiting for go.
    int          m_mode = 0;
    int          m_since_rel = 0;
    logic [15:0] m_retired = '0;
    logic        m_illegal = 1'b0;

    uc_seq #(.BOOT_CYCLES(BOOT), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .go(go),
        .dbg_en(dbg_en), .dbg_step(dbg_step),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op(op),
        .pc_en(pc_en), .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic bit m_exec();
        return m_mode == 1 && (!dbg_en || dbg_step);
    endfunction

    function automatic bit is_defined(input int o);
        return (o / 8 == 1) || (o >= 0 && o <= 7 && o != 1);
    endfunction

    // Expected {pc_en, s_inc, s_inm, we3, wez, op}
    function automatic logic [7:0] m_ctrl();
        int o;
        o = int'(opcode);
        if ((m_mode == 2 || m_mode == 3) && go) return 8'b1100_0000;
        if (!m_exec()) return 8'b0100_0000;
        if (o / 8 == 1) return {5'b11011, 3'(o % 8)};
        case (o)
            2:       return 8'b1111_0000;
            4:       return 8'b1000_0000;
            5:       return {1'b1, !z, 6'b0};
            6:       return {1'b1, z, 6'b0};
            7:       return 8'b0100_0000;
            3:       return {go, 7'b100_0000};
            default: return 8'b1100_0000;
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0] c;
        c = m_ctrl();
        if (c[7]) m_retired = m_retired + 16'd1;
        case (m_mode)
            0: begin
                m_since_rel++;
                if (m_since_rel >= ((BOOT > 0) ? BOOT : 1)) m_mode = 1;
            end
            1: if (m_exec()) begin
                if (!is_defined(int'(opcode))) m_illegal = 1'b1;
                if (opcode == 6'd7) m_mode = 2;
                else if (opcode == 6'd3 && !go) m_mode = 3;
            end
            default: if (go) m_mode = 1;
        endcase
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_since_rel = 0;
        m_retired = '0;
        m_illegal = 1'b0;
    endtask

    task automatic check(input string tag);
        logic [7:0] exp_c;
        exp_c = m_ctrl();
        n_vec++;
        assert ({pc_en, s_inc, s_inm, we3, wez, op} === exp_c) else begin
            n_err++;
            $error("FAIL %s ctrl{pc_en,s_inc,s_inm,we3,wez,op}: got %b want %b", tag,
                   {pc_en, s_inc, s_inm, we3, wez, op}, exp_c);
        end
        n_vec++;
        assert ({halted, illegal} === {m_mode == 2, m_illegal}) else begin
            n_err++;
            $error("FAIL %s status{halted,illegal}: got %b want %b", tag,
                   {halted, illegal}, {m_mode == 2, m_illegal});
        end
        n_vec++;
        assert (retired === m_retired) else begin
            n_err++;
            $error("FAIL %s retired: got %0d want %0d", tag, retired, m_retired);
        end
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        check(tag);
        if (reset) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] o, input logic zz, input logic g,
                         input logic de, input logic ds);
        opcode = o; z = zz; go = g; dbg_en = de; dbg_step = ds;
    endtask

    initial begin
        // 1: reset held, then boot settling
        model_reset();
        drive(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick("reset");
        reset = 1'b1;
        repeat (3) tick("boot");
        n_vec++;
        assert (retired === 16'd1) else begin
            n_err++;
            $error("FAIL boot_retired: got %0d want 1", retired);
        end

        // 2: ALU and LI decode
        drive(6'b001011, 1'b0, 1'b0, 1'b0, 1'b0); tick("alu011");
        drive(6'b001110, 1'b1, 1'b0, 1'b0, 1'b0); tick("alu110");
        drive(6'b000010, 1'b0, 1'b0, 1'b0, 1'b0); tick("li");

        // 3: branches
        drive(6'b000101, 1'b1, 1'b0, 1'b0, 1'b0); tick("jz_z1");
        drive(6'b000101, 1'b0, 1'b0, 1'b0, 1'b0); tick("jz_z0");
        drive(6'b000110, 1'b1, 1'b0, 1'b0, 1'b0); tick("jnz_z1");
        drive(6'b000110, 1'b0, 1'b0, 1'b0, 1'b0); tick("jnz_z0");
        drive(6'b000100, 1'b1, 1'b0, 1'b0, 1'b0); tick("j");

        // 4: HALT, idle, resume
        drive(6'b000111, 1'b0, 1'b0, 1'b0, 1'b0); tick("halt_enter");
        repeat (10) tick("halt_idle");
        go = 1'b1; tick("halt_go");
        go = 1'b0; drive(6'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick("after_halt");

        // 5: WAIT with and without go
        drive(6'b000011, 1'b0, 1'b0, 1'b0, 1'b0); tick("wait_enter");
        repeat (5) tick("stall_idle");
        go = 1'b1; tick("stall_go");
        go = 1'b0; drive(6'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick("after_stall");
        drive(6'b000011, 1'b0, 1'b1, 1'b0, 1'b0); tick("wait_go_nop");
        drive(6'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick("after_wait_nop");

        // 6: single-step debug, illegal opcode, reset during HALT
        drive(6'b001001, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) tick("dbg_nostep");
        dbg_step = 1'b1; tick("dbg_step1");
        dbg_step = 1'b0; tick("dbg_gap");
        dbg_step = 1'b1; tick("dbg_step2");
        drive(6'b111111, 1'b0, 1'b0, 1'b0, 1'b0); tick("illegal_op");
        drive(6'd0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (2) tick("illegal_sticky");
        drive(6'b000111, 1'b0, 1'b0, 1'b0, 1'b0); tick("halt2");
        tick("halt2_idle");
        reset = 1'b0; model_reset();
        #1 check("reset_in_halt");
        tick("reset_hold");
        reset = 1'b1;
        repeat (3) tick("reboot");

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            logic [5:0] pick [16];
            pick = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8,
                     6'd9, 6'd11, 6'd13, 6'd15, 6'd63, 6'd20, 6'd1, 6'd3};
            drive(pick[$urandom_range(0, 15)], 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)));
            if (i == 200) begin
                reset = 1'b0; model_reset();
                tick("rand_reset");
                reset = 1'b1;
            end
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
